serial_sum_receiver: RTL and testbench
======================================

Name: serial_sum_receiver

Overview:
Receiving end of the bit-serial sum link: captures an LSB-first serial stream of a sum word, one bit per clock, and reassembles it into a parallel word.
Sits downstream of the serial adder/shifter and presents each completed sum with a one-cycle valid strobe.
Also provides a busy flag, a sticky overrun/abort flag and a completed-frame counter for debug.

Parameters:
reglength, 3, operand width of the transmitting adder; the received word width is W = reglength+1 (sum includes carry); legal values >= 1

Ports:
clk  input  1  system clock, all state changes on posedge
reset  input  1  asynchronous, active-low reset; low forces all state to reset values immediately
start  input  1  frame-start strobe; high in the cycle carrying bit 0 of a frame
sin  input  1  serial data, LSB first, sampled on posedge clk
word  output  reglength+1  last completed received word
valid  output  1  one-cycle pulse: word has just been updated
busy  output  1  high while a frame is partially received
overrun  output  1  sticky: a frame was aborted by a new start
frame_cnt  output  8  count of completed frames, wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit counter=0, word=0, valid=0, busy=0, overrun=0, frame_cnt=0.
- Release of reset is synchronous in effect: the first capture is the first posedge with reset=1.
- Internal W-bit shift register: each capture does shreg <= {sin, shreg[W-1:1]}. After W captures, bit 0 holds the first-received (LSB) bit.
- Bit counter width: clog2(W)+1 bits, wide enough to hold W.
- FSM states:
  - IDLE: busy=0. On a posedge with start=1, capture sin as bit 0, set count=1, go to RECV. With start=0, hold state; sin is ignored.
  - RECV: busy=1. Each posedge with start=0 captures sin and increments count.
  - RECV, last bit: on the edge where count==W-1 (the W-th bit is captured):
    - word <= the complete assembled value ({sin, shreg[W-1:1]})
    - valid <= 1
    - frame_cnt increments
    - next state IDLE
- valid: high for exactly the one cycle following the last-bit edge; deasserts on the next posedge unless another frame completes on that edge.
- word holds its value until the next completed frame. Aborted frames never change word.
- Latency: start accepted at edge k; word and valid become visible after edge k+W-1. A frame occupies W consecutive clocks and no gaps are allowed.
- Back-to-back frames: start may assert on the edge immediately after a last-bit edge (state is IDLE then). Throughput is one word per W cycles.
- start=1 while in RECV (abort/restart):
  - Discard the partial frame.
  - Capture sin as bit 0 of the new frame, set count=1, remain in RECV.
  - Set overrun=1. overrun clears only on reset.
  - word, valid and frame_cnt are unchanged.
- start=1 on the last-bit edge of a frame: abort/restart takes priority. The old frame does not complete, overrun=1, and the new frame starts with count=1.
- W=2 (reglength=1): start edge plus one more edge completes a frame. The counter logic must handle this minimum width.
- Reset asserted mid-frame: partial data is lost, all outputs return to reset values, and no valid pulse is generated.
- frame_cnt: 8-bit unsigned, increments once per completed frame, 255+1 wraps to 0 with no flag.

Test Plan:
- reglength=3; after reset, check word=0, valid=0, busy=0, overrun=0, frame_cnt=0. Then send start with sin bits 1,0,0,1 on 4 consecutive edges -> word=9 and valid=1 for exactly one cycle after the 4th edge; busy=1 after edges 1-3; frame_cnt=1.
- Max sum 7+7=14: send bits 0,1,1,1 -> word=14 (4'b1110). Then send 1,1,1,1 -> word=15. valid pulses twice; frame_cnt=2.
- Back-to-back: frames 5 (1,0,1,0) and 10 (0,1,0,1) with start re-asserted on the edge right after the first frame's last bit -> word=5, then word=10, two single-cycle valid pulses 4 cycles apart, overrun stays 0.
- Abort: start, bits 1,1, then start again followed by 0,0,1,0 -> overrun=1, word=4 after the restarted frame completes, and only one valid pulse from the start of the test.
- Reset mid-frame: start, 2 bits, then reset=0 asynchronously between edges -> outputs are 0 immediately. After release, a 4-bit frame 0,1,1,0 yields word=6.
- Counter wrap: 256 completed frames -> frame_cnt=0. With reglength=1, frame 1,1 -> word=3 after 2 edges.

Source files
------------

// File: rtl/serial_sum_receiver_if.sv
// Link between the bit-serial sum transmitter and its receiver.
// The master drives the frame strobe and serial bit; the slave returns the word and its status.
interface serial_sum_receiver_if #(
    parameter int W = 4
) ();
    logic         start;
    logic         sin;
    logic [W-1:0] word;
    logic         valid;
    logic         busy;
    logic         overrun;
    logic [7:0]   frame_cnt;

    modport master (
        output start, sin,
        input  word, valid, busy, overrun, frame_cnt
    );

    modport slave (
        input  start, sin,
        output word, valid, busy, overrun, frame_cnt
    );
endinterface

// File: rtl/serial_sum_receiver.sv
// Reassembles an LSB-first serial sum word (reglength+1 bits) into a parallel word,
// with a single-cycle valid strobe, busy flag, sticky overrun flag and a frame counter.
//
// state | meaning
// IDLE  | waiting for start; sin ignored
// RECV  | frame partially received; busy high
module serial_sum_receiver #(
    parameter int reglength = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_sum_receiver_if.slave rx
);
    localparam int W  = reglength + 1;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   shreg_q;
    logic [W-1:0]   shift_w;
    logic [W-1:0]   word_q;
    logic [CW-1:0]  cnt_q;
    logic           valid_q;
    logic           overrun_q;
    logic [7:0]     frame_cnt_q;
    logic           busy_c;
    logic           last_bit;

    assign shift_w  = {rx.sin, shreg_q[W-1:1]};
    // a start on the final bit edge restarts the frame instead of completing it
    assign last_bit = (state_q == RECV) && !rx.start && (cnt_q == CW'(W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rx.start) state_d = RECV;
            RECV: begin
                if (rx.start) begin
                    state_d = RECV;
                end else if (last_bit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        if (state_q == RECV) busy_c = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (rx.start) begin
                shreg_q <= shift_w;
                cnt_q   <= CW'(1);
                if (state_q == RECV) overrun_q <= 1'b1;
            end else if (state_q == RECV) begin
                shreg_q <= shift_w;
                cnt_q   <= cnt_q + CW'(1);
                if (last_bit) begin
                    word_q      <= shift_w;
                    valid_q     <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
        end
    end

    assign rx.word      = word_q;
    assign rx.valid     = valid_q;
    assign rx.busy      = busy_c;
    assign rx.overrun   = overrun_q;
    assign rx.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_serial_sum_receiver.sv
// Bench for serial_sum_receiver: directed frames on a W=4 and a W=2 instance,
// expected words and frame counts queued at stimulus time and checked by valid-driven monitors.
module tb_serial_sum_receiver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_sum_receiver_if #(.W(4)) ifa ();
    serial_sum_receiver_if #(.W(2)) ifb ();

    serial_sum_receiver #(.reglength(3)) dut_a (.clk(clk), .reset(rst), .rx(ifa));
    serial_sum_receiver #(.reglength(1)) dut_b (.clk(clk), .reset(rst), .rx(ifb));

    logic [11:0] qa[$];
    logic [9:0]  qb[$];
    logic [7:0]  exp_cnt_a = 8'd0;
    logic [7:0]  exp_cnt_b = 8'd0;
    int          pulses_a = 0;
    int          vcyc_last = 0;
    int          vcyc_prev = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.valid === 1'b1) begin
            logic [11:0] e;
            pulses_a++;
            vcyc_prev = vcyc_last;
            vcyc_last = cyc;
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got word %0d expected no valid", ifa.word);
            end else begin
                e = qa.pop_front();
                chk("a_word", 32'(ifa.word), 32'(e[3:0]));
                chk("a_frame_cnt", 32'(ifa.frame_cnt), 32'(e[11:4]));
            end
        end
        if (ifb.valid === 1'b1) begin
            logic [9:0] e;
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got word %0d expected no valid", ifb.word);
            end else begin
                e = qb.pop_front();
                chk("b_word", 32'(ifb.word), 32'(e[1:0]));
                chk("b_frame_cnt", 32'(ifb.frame_cnt), 32'(e[9:2]));
            end
        end
    end

    task automatic drive_a(input logic s, input logic d);
        @(negedge clk);
        ifa.start = s;
        ifa.sin   = d;
    endtask

    task automatic drive_b(input logic s, input logic d);
        @(negedge clk);
        ifb.start = s;
        ifb.sin   = d;
    endtask

    task automatic push_a(input logic [3:0] v);
        exp_cnt_a = exp_cnt_a + 8'd1;
        qa.push_back({exp_cnt_a, v});
    endtask

    task automatic push_b(input logic [1:0] v);
        exp_cnt_b = exp_cnt_b + 8'd1;
        qb.push_back({exp_cnt_b, v});
    endtask

    task automatic send_a(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            drive_a(i == 0, v[i]);
            if (i > 0) chk("a_busy_mid_frame", 32'(ifa.busy), 32'd1);
        end
        push_a(v);
    endtask

    initial begin
        ifa.start = 1'b0;
        ifa.sin   = 1'b0;
        ifb.start = 1'b0;
        ifb.sin   = 1'b0;
        #2;
        chk("reset_word", 32'(ifa.word), 32'd0);
        chk("reset_valid", 32'(ifa.valid), 32'd0);
        chk("reset_busy", 32'(ifa.busy), 32'd0);
        chk("reset_overrun", 32'(ifa.overrun), 32'd0);
        chk("reset_frame_cnt", 32'(ifa.frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // frame 9 with explicit one-cycle valid check
        send_a(4'd9);
        drive_a(1'b0, 1'b0);
        chk("f9_valid_high", 32'(ifa.valid), 32'd1);
        chk("f9_word", 32'(ifa.word), 32'd9);
        chk("f9_busy_done", 32'(ifa.busy), 32'd0);
        drive_a(1'b0, 1'b0);
        chk("f9_valid_low", 32'(ifa.valid), 32'd0);
        chk("f9_word_hold", 32'(ifa.word), 32'd9);

        // maximum sums
        send_a(4'd14);
        drive_a(1'b0, 1'b0);
        send_a(4'd15);
        drive_a(1'b0, 1'b0);
        drive_a(1'b0, 1'b0);

        // back-to-back frames
        send_a(4'd5);
        send_a(4'd10);
        drive_a(1'b0, 1'b0);
        drive_a(1'b0, 1'b0);
        chk("b2b_pulse_spacing", 32'(vcyc_last - vcyc_prev), 32'd4);
        chk("b2b_overrun", 32'(ifa.overrun), 32'd0);
        chk("b2b_word", 32'(ifa.word), 32'd10);

        // abort mid-frame and restart
        begin
            int p0;
            p0 = pulses_a;
            drive_a(1'b1, 1'b1);
            drive_a(1'b0, 1'b1);
            drive_a(1'b1, 1'b0);
            chk("abort_word_unchanged", 32'(ifa.word), 32'd10);
            drive_a(1'b0, 1'b0);
            chk("abort_overrun", 32'(ifa.overrun), 32'd1);
            drive_a(1'b0, 1'b1);
            drive_a(1'b0, 1'b0);
            push_a(4'd4);
            drive_a(1'b0, 1'b0);
            drive_a(1'b0, 1'b0);
            chk("abort_pulses", 32'(pulses_a - p0), 32'd1);
            chk("abort_word", 32'(ifa.word), 32'd4);
        end

        // start on the last-bit edge wins over completion
        drive_a(1'b1, 1'b1);
        drive_a(1'b0, 1'b1);
        drive_a(1'b0, 1'b1);
        drive_a(1'b1, 1'b0);
        drive_a(1'b0, 1'b1);
        drive_a(1'b0, 1'b0);
        drive_a(1'b0, 1'b0);
        push_a(4'd2);
        drive_a(1'b0, 1'b0);
        drive_a(1'b0, 1'b0);
        chk("lastedge_abort_word", 32'(ifa.word), 32'd2);

        // asynchronous reset mid-frame
        drive_a(1'b1, 1'b1);
        drive_a(1'b0, 1'b1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midreset_word", 32'(ifa.word), 32'd0);
        chk("midreset_busy", 32'(ifa.busy), 32'd0);
        chk("midreset_overrun", 32'(ifa.overrun), 32'd0);
        chk("midreset_frame_cnt", 32'(ifa.frame_cnt), 32'd0);
        chk("midreset_pending", 32'(qa.size()), 32'd0);
        exp_cnt_a = 8'd0;
        ifa.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_a(4'd6);
        drive_a(1'b0, 1'b0);
        drive_a(1'b0, 1'b0);
        chk("postreset_word", 32'(ifa.word), 32'd6);

        // frame counter wrap: 1 + 255 frames
        for (int i = 0; i < 255; i++) send_a(4'(i));
        drive_a(1'b0, 1'b0);
        drive_a(1'b0, 1'b0);
        chk("wrap_frame_cnt", 32'(ifa.frame_cnt), 32'd0);

        // minimum width instance
        drive_b(1'b1, 1'b1);
        drive_b(1'b0, 1'b1);
        chk("b_busy", 32'(ifb.busy), 32'd1);
        push_b(2'd3);
        drive_b(1'b0, 1'b0);
        chk("b_valid", 32'(ifb.valid), 32'd1);
        chk("b_word3", 32'(ifb.word), 32'd3);
        drive_b(1'b1, 1'b0);
        drive_b(1'b1, 1'b1);
        drive_b(1'b0, 1'b0);
        push_b(2'd1);
        drive_b(1'b0, 1'b0);
        drive_b(1'b0, 1'b0);
        chk("b_overrun", 32'(ifb.overrun), 32'd1);
        chk("b_word1", 32'(ifb.word), 32'd1);
        chk("b_frame_cnt_final", 32'(ifb.frame_cnt), 32'd2);

        drive_a(1'b0, 1'b0);
        chk("a_pending_at_end", 32'(qa.size()), 32'd0);
        chk("b_pending_at_end", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
